// File: rtl/sum_sched_pkg.sv
// Shared constants and helpers for the four-channel summer frame scheduler.
package sum_sched_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_LEN_W  = 16;
  localparam int DEF_ERR_W  = 8;

  typedef logic [1:0] sched_state_t;

  localparam sched_state_t ST_IDLE  = 2'd0;
  localparam sched_state_t ST_RUN   = 2'd1;
  localparam sched_state_t ST_FLUSH = 2'd2;

  // A programmed length of zero is treated as a single-beat frame.
  function automatic int unsigned norm_frame_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/frame_beat_counter.sv
// Tracks the beat position inside the current frame and counts closed frames.
module frame_beat_counter
  import sum_sched_pkg::*;
#(
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             advance,
  input  logic             abort,
  input  logic [LEN_W-1:0] frame_len,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             expected_last,
  output logic [LEN_W-1:0] frame_cnt
);

  assign expected_last = (beat_cnt == frame_len - LEN_W'(1));

  // A misaligned beat closes the frame early, so it counts as a frame too.
  always_ff @(posedge clock) begin
    if (reset) begin
      beat_cnt  <= '0;
      frame_cnt <= '0;
    end else if (start) begin
      beat_cnt <= '0;
    end else if (advance) begin
      if (abort || expected_last) begin
        beat_cnt  <= '0;
        frame_cnt <= frame_cnt + LEN_W'(1);
      end else begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: rtl/sum_frame_scheduler.sv
// Joins per-channel handshakes into one beat-aligned stream, enforces frame
// length and flushes misaligned channels so every output frame is terminated.
module sum_frame_scheduler
  import sum_sched_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ERR_W  = DEF_ERR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic [LEN_W-1:0]  cfg_frame_len,
  input  logic [NUM_CH-1:0] cfg_chan_mask,
  input  logic [NUM_CH-1:0] s_tvalid,
  input  logic [NUM_CH-1:0] s_tlast,
  output logic [NUM_CH-1:0] s_tready,
  output logic              sum_load,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic [LEN_W-1:0]  frame_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [1:0]        state
);

  logic [LEN_W-1:0]  len_q;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] done_nxt;
  logic [NUM_CH-1:0] last_exp;
  logic [1:0]        state_nxt;
  logic [LEN_W-1:0]  beat_cnt;
  logic              expected_last;
  logic              start;
  logic              all_valid;
  logic              room;
  logic              load;
  logic              misalign;
  logic              flush_done;

  assign start     = (state == ST_IDLE) && cfg_enable && (cfg_chan_mask != '0);
  assign all_valid = ((s_tvalid & mask_q) == mask_q);
  assign room      = !m_tvalid || m_tready;
  assign load      = (state == ST_RUN) && all_valid && room;
  assign last_exp  = expected_last ? mask_q : '0;
  assign misalign  = load && ((s_tlast & mask_q) != last_exp);
  assign sum_load  = load;

  frame_beat_counter #(.LEN_W(LEN_W)) u_beat (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .advance       (load),
    .abort         (misalign),
    .frame_len     (len_q),
    .beat_cnt      (beat_cnt),
    .expected_last (expected_last),
    .frame_cnt     (frame_cnt)
  );

  // Masked-off channels are always drained so they never stall upstream.
  always_comb begin
    s_tready = '0;
    case (state)
      ST_RUN:   s_tready = ~mask_q | {NUM_CH{load}};
      ST_FLUSH: s_tready = ~(mask_q & done_q);
      default:  s_tready = '0;
    endcase
  end

  always_comb begin
    done_nxt   = done_q | (mask_q & s_tvalid & s_tlast);
    flush_done = ((done_nxt & mask_q) == mask_q);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (misalign)
          state_nxt = ST_FLUSH;
        else if (!cfg_enable && load && expected_last)
          state_nxt = ST_IDLE;
        else if (!cfg_enable && !load && (beat_cnt == '0))
          state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        if (flush_done) state_nxt = cfg_enable ? ST_RUN : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      len_q    <= LEN_W'(1);
      mask_q   <= '0;
      done_q   <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        len_q  <= LEN_W'(norm_frame_len(32'(cfg_frame_len)));
        mask_q <= cfg_chan_mask;
      end
      if (misalign)
        done_q <= s_tlast & mask_q;
      else if (state == ST_FLUSH)
        done_q <= flush_done ? '0 : done_nxt;
      // Output stage: holds its beat until the downstream accepts it.
      if (load) begin
        m_tvalid <= 1'b1;
        m_tlast  <= misalign || expected_last;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
        m_tlast  <= 1'b0;
      end
      if (misalign && (err_cnt != '1))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_sum_frame_scheduler.sv
// Directed and randomised bench for sum_frame_scheduler, compared every cycle
// against a beat-level reference model of the joining and framing rules.
module tb_sum_frame_scheduler;

  localparam int NC = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_frame_len = 16'd4;
  logic [3:0]  cfg_chan_mask = 4'h0;
  logic [3:0]  s_tvalid = 4'h0;
  logic [3:0]  s_tlast = 4'h0;
  logic [3:0]  s_tready;
  logic        sum_load;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic [1:0]  state;

  sum_frame_scheduler #(.NUM_CH(4), .LEN_W(16), .ERR_W(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_enable    (cfg_enable),
    .cfg_frame_len (cfg_frame_len),
    .cfg_chan_mask (cfg_chan_mask),
    .s_tvalid      (s_tvalid),
    .s_tlast       (s_tlast),
    .s_tready      (s_tready),
    .sum_load      (sum_load),
    .m_tvalid      (m_tvalid),
    .m_tlast       (m_tlast),
    .m_tready      (m_tready),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt),
    .state         (state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: 0 idle, 1 run, 2 flush
  int       ms = 0, mbeat = 0, mflen = 1, mframes = 0, merrs = 0;
  bit [3:0] mmask = 4'h0, mdone = 4'h0;
  bit       mv = 1'b0, ml = 1'b0;

  // Per-channel stream generators
  int         gpos [NC];
  int         glen = 1;
  int         early_ch = -1, early_pos = 0;
  int         vprob = 100, rmode = 0, inj_prob = 0;
  logic [3:0] vforce = 4'h0;

  int n_load, n_acc, n_lastacc, first_last, n_flush;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      s_tvalid[i] = vforce[i] || (int'($urandom_range(99, 0)) < vprob);
      s_tlast[i]  = (gpos[i] == glen - 1) || (i == early_ch && gpos[i] == early_pos) ||
                    (int'($urandom_range(999, 0)) < inj_prob);
    end
    case (rmode)
      0: m_tready = 1'b1;
      1: m_tready = ~m_tready;
      2: m_tready = (int'($urandom_range(99, 0)) < 70);
      default: m_tready = 1'b0;
    endcase
  endtask

  task automatic tick();
    logic [3:0] er;
    bit el, xl, aligned;
    @(negedge clock);
    er = 4'h0;
    el = 1'b0;
    if (ms == 1) begin
      el = ((s_tvalid & mmask) == mmask) && (!mv || m_tready);
      er = ~mmask | {4{el}};
    end else if (ms == 2) begin
      er = ~(mmask & mdone);
    end
    chk("s_tready", s_tready, er);
    chk("sum_load", sum_load, el);
    chk("m_tvalid", m_tvalid, mv);
    if (mv) chk("m_tlast", m_tlast, ml);
    chk("frame_cnt", frame_cnt, mframes);
    chk("err_cnt", err_cnt, merrs);
    chk("state", state, ms);

    if (sum_load) n_load++;
    if (m_tvalid && m_tready) begin
      n_acc++;
      if (m_tlast) begin
        n_lastacc++;
        if (first_last == 0) first_last = n_acc;
      end
    end
    if (state == 2'd2) n_flush++;

    for (int i = 0; i < NC; i++) begin
      if (s_tvalid[i] && er[i]) begin
        if (i == early_ch && s_tlast[i]) early_ch = -1;
        gpos[i] = s_tlast[i] ? 0 : gpos[i] + 1;
      end
    end

    if (reset) begin
      ms = 0; mbeat = 0; mv = 0; ml = 0; mframes = 0; merrs = 0; mdone = 4'h0;
      for (int i = 0; i < NC; i++) gpos[i] = 0;
    end else begin
      if (el) mv = 1'b1;
      else if (m_tready) mv = 1'b0;
      case (ms)
        0: if (cfg_enable && cfg_chan_mask != 4'h0) begin
             ms = 1;
             mflen = (cfg_frame_len == 16'd0) ? 1 : int'(cfg_frame_len);
             mmask = cfg_chan_mask;
             mbeat = 0;
             glen = mflen;
             for (int i = 0; i < NC; i++) gpos[i] = 0;
           end
        1: if (el) begin
             xl = (mbeat == mflen - 1);
             aligned = 1'b1;
             for (int i = 0; i < NC; i++)
               if (mmask[i] && (s_tlast[i] != xl)) aligned = 1'b0;
             if (aligned) begin
               ml = xl;
               if (xl) begin
                 mbeat = 0;
                 mframes = (mframes + 1) & 16'hFFFF;
                 if (!cfg_enable) ms = 0;
               end else begin
                 mbeat++;
               end
             end else begin
               ml = 1'b1;
               mframes = (mframes + 1) & 16'hFFFF;
               merrs = (merrs < 255) ? merrs + 1 : 255;
               mbeat = 0;
               mdone = s_tlast & mmask;
               ms = 2;
             end
           end else if (!cfg_enable && mbeat == 0) begin
             ms = 0;
           end
        default: begin
          for (int i = 0; i < NC; i++)
            if (mmask[i] && !mdone[i] && s_tvalid[i] && s_tlast[i]) mdone[i] = 1'b1;
          if (mdone == mmask) begin
            mdone = 4'h0;
            ms = cfg_enable ? 1 : 0;
          end
        end
      endcase
    end
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      drive();
      tick();
    end
  endtask

  task automatic start_test(input int len, input logic [3:0] mask, input int vp, input int rm);
    reset = 1'b0;
    cfg_frame_len = 16'(len);
    cfg_chan_mask = mask;
    vprob = vp;
    rmode = rm;
    vforce = 4'h0;
    inj_prob = 0;
    early_ch = -1;
    m_tready = 1'b1;
    cfg_enable = 1'b1;
    n_load = 0; n_acc = 0; n_lastacc = 0; first_last = 0; n_flush = 0;
  endtask

  task automatic stop_test();
    int k;
    cfg_enable = 1'b0;
    vforce = 4'hF;
    rmode = 0;
    inj_prob = 0;
    early_ch = -1;
    k = 0;
    while (!(ms == 0 && !mv) && k < 100) begin
      drive();
      tick();
      k++;
    end
    chk("stop_within_bound", (k < 100), 1);
  endtask

  initial begin
    run(3);
    chk("rst_state", state, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_frame_cnt", frame_cnt, 0);

    // Clean 4-beat frame at full throughput
    start_test(4, 4'hF, 100, 0);
    run(5);
    vprob = 0;
    cfg_enable = 1'b0;
    run(2);
    chk("t1_loads", n_load, 4);
    chk("t1_accepted", n_acc, 4);
    chk("t1_last_pos", first_last, 4);
    chk("t1_last_count", n_lastacc, 1);
    chk("t1_frame_cnt", frame_cnt, 1);
    chk("t1_err_cnt", err_cnt, 0);
    chk("t1_idle", state, 0);
    stop_test();

    // Downstream ready toggling every cycle
    start_test(4, 4'hF, 100, 1);
    run(24);
    stop_test();
    chk("t2_no_loss", n_acc, n_load);
    chk("t2_whole_frames", n_load, 4 * n_lastacc);

    // Channel 2 ends its frame on beat 1
    start_test(4, 4'hF, 100, 0);
    early_ch = 2;
    early_pos = 1;
    run(14);
    stop_test();
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_flush_cycles", n_flush, 2);
    chk("t3_first_last", first_last, 2);
    chk("t3_frames", n_lastacc, 4);

    // Only channels 0/1 enabled; 2/3 must be drained continuously
    start_test(3, 4'b0011, 60, 2);
    vforce = 4'b1100;
    for (int k = 0; k < 40; k++) begin
      drive();
      tick();
      if (state == 2'd1) chk("t4_masked_ready", s_tready[3:2], 2'b11);
    end
    stop_test();
    chk("t4_err_cnt", err_cnt, 1);
    chk("t4_whole_frames", n_load, 3 * n_lastacc);

    // Enable dropped at beat 1 of a 4-beat frame
    start_test(4, 4'hF, 100, 0);
    run(2);
    cfg_enable = 1'b0;
    run(6);
    chk("t5_loads", n_load, 4);
    chk("t5_last_count", n_lastacc, 1);
    chk("t5_idle", state, 0);
    chk("t5_tready_low", s_tready, 0);
    stop_test();

    // Heavy misalignment drives the error counter into saturation
    start_test(4, 4'hF, 100, 0);
    inj_prob = 400;
    run(2000);
    stop_test();
    chk("sat_err_cnt", err_cnt, 8'hFF);

    // Reset while an output beat is pending
    start_test(4, 4'hF, 100, 3);
    run(2);
    chk("t6_pending", m_tvalid, 1);
    reset = 1'b1;
    run(1);
    chk("t6_rst_m_tvalid", m_tvalid, 0);
    chk("t6_rst_m_tlast", m_tlast, 0);
    chk("t6_rst_sum_load", sum_load, 0);
    chk("t6_rst_tready", s_tready, 0);
    chk("t6_rst_frame_cnt", frame_cnt, 0);
    chk("t6_rst_err_cnt", err_cnt, 0);
    chk("t6_rst_state", state, 0);
    start_test(1, 4'hF, 100, 0);
    run(8);
    stop_test();
    chk("t6_beats", n_acc, 8);
    chk("t6_lasts", n_lastacc, 8);

    // Random traffic, configuration churn and occasional resets
    vprob = 80;
    rmode = 2;
    inj_prob = 30;
    vforce = 4'h0;
    early_ch = -1;
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(299, 0) == 0);
      cfg_enable = ($urandom_range(99, 0) < 90);
      cfg_frame_len = 16'($urandom_range(5, 0));
      cfg_chan_mask = 4'($urandom_range(15, 0));
      drive();
      tick();
    end
    reset = 1'b0;
    stop_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
